filter_feeder: RTL
==================

Name: filter_feeder

Overview:
- Upstream stage of the median filter block: accepts a valid/ready byte stream and writes each sample into the filter's 8-entry window via data_in/reg_addr/wr_enable.
- Uses round-robin (ring) addressing and waits a fixed settle time for the median result after each write.
- Pulses result_valid once the window is full and the median is settled.
- Supports a flush that zero-fills the filter window, and registers the output-mode select so it only changes between samples.

Parameters:
- DATA_W, 8, sample width.
- DEPTH, 8, window entries; must be a power of 2.
- ADDR_W, 3, log2(DEPTH).
- SETTLE_CYCLES, 2, cycles from write to settled median, 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  sample.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- flush_req  in  1  request zero-fill of the window (level, sampled in ACCEPT).
- mode_cfg  in  2  requested output select: 2'b10 pass, 2'b01 difference, others median.
- data_in  out  DATA_W  write data to filter.
- reg_addr  out  ADDR_W  write address to filter.
- wr_enable  out  1  one-cycle write strobe.
- out_select  out  2  registered mode to filter.
- window_full  out  1  fill_count == DEPTH.
- result_valid  out  1  one-cycle pulse: filter output is a settled median of a full window.

Behaviour:
- States: ACCEPT, WRITE, SETTLE, FLUSH.
- Reset: synchronous rst=1 in any state, including mid-SETTLE or mid-FLUSH:
  - state=ACCEPT, wr_ptr=0, fill_count=0, settle_cnt=0, flush_idx=0.
  - data_in=0, reg_addr=0, wr_enable=0, out_select=0, result_valid=0.
  - in_ready=0 while rst=1.
  - Reset performs no flush; the filter's own reset clears its storage.
- in_ready = (state==ACCEPT) && !flush_req && !rst. It is combinational from state and flush_req.
- ACCEPT:
  - out_select <= mode_cfg every cycle.
  - flush_req=1 has priority over in_valid: go to FLUSH, flush_idx=0.
  - Otherwise, on handshake at cycle T: latch in_data into data_in, reg_addr <= wr_ptr, go to WRITE.
- WRITE (cycle T+1):
  - wr_enable=1 for exactly this cycle.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 to 0.
  - fill_count <= min(fill_count+1, DEPTH), saturating.
  - If SETTLE_CYCLES==0, go to ACCEPT; else go to SETTLE with settle_cnt=SETTLE_CYCLES-1.
- SETTLE (cycles T+2 .. T+1+SETTLE_CYCLES):
  - Decrement settle_cnt; at 0, go to ACCEPT.
  - out_select frozen; in_valid ignored.
- Return to ACCEPT (cycle T+2+SETTLE_CYCLES):
  - result_valid=1 for that one cycle iff fill_count==DEPTH; it is registered.
  - in_ready is high in the same cycle.
  - A new handshake in that cycle is legal.
  - Throughput: one sample per SETTLE_CYCLES+2 cycles.
- FLUSH:
  - For DEPTH cycles: wr_enable=1, data_in=0, reg_addr=flush_idx; flush_idx increments.
  - After the last write: wr_ptr=0, fill_count=0, window_full=0, go to ACCEPT.
  - No result_valid is generated.
  - flush_req is ignored during FLUSH. If still high on return, a second flush starts.
- window_full is registered from fill_count. It stays 1 (saturated) until flush or rst.
- The first DEPTH-1 samples produce no result_valid. The DEPTH-th sample and every later sample produce one.
- in_data is held by the register; the source may change it after the handshake.

Decomposition:
- Package filter_pkg:
  - DATA_W, DEPTH, ADDR_W.
  - State enum filter_feeder_state_t {ACCEPT, WRITE, SETTLE, FLUSH}.
  - Mode constants SEL_PASS=2'b10, SEL_DIFF=2'b01, SEL_MEDIAN=2'b00.
- One natural sub-module: filter_ring_ptr, a wrapping ADDR_W counter with increment and clear, reused for wr_ptr and flush_idx.
- All other logic stays in filter_feeder.

Test Plan:
- Fill: after rst, send 8 samples 10,20,..,80 back to back with in_valid=1, SETTLE_CYCLES=2.
  - Writes go to addr 0..7, one per 4 cycles.
  - result_valid is first high exactly 4 cycles after the 8th handshake (T+4); no earlier pulses.
  - window_full=1 from that point.
- Wrap: a 9th sample 99 writes reg_addr=0 with data_in=99, and result_valid pulses at T+4.
- Flush: with a full window, raise flush_req together with in_valid.
  - in_ready=0, no sample accepted.
  - 8 consecutive wr_enable cycles, addr 0..7, data 0.
  - Then window_full=0, and the next sample goes to addr 0.
- Reset mid-op: assert rst in the SETTLE cycle after writing sample 5.
  - All outputs 0 next cycle, no result_valid.
  - Next sample writes addr 0; 8 more samples are needed before result_valid.
- Mode hold: change mode_cfg 00→10 during SETTLE.
  - out_select stays 00 until the ACCEPT cycle, then becomes 10.
- Backpressure/zero settle: with SETTLE_CYCLES=0, toggle in_valid.
  - Each handshake yields wr_enable at T+1 and in_ready at T+2.
  - Samples are never duplicated or dropped.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared widths, state encoding and output-mode constants for the median filter front end.
package filter_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        ACCEPT,
        WRITE,
        SETTLE,
        FLUSH
    } filter_feeder_state_t;

    localparam logic [1:0] SEL_PASS   = 2'b10;
    localparam logic [1:0] SEL_DIFF   = 2'b01;
    localparam logic [1:0] SEL_MEDIAN = 2'b00;

    // Anything other than pass or difference collapses onto the median select.
    function automatic logic [1:0] decode_mode(input logic [1:0] mode);
        case (mode)
            SEL_PASS: decode_mode = SEL_PASS;
            SEL_DIFF: decode_mode = SEL_DIFF;
            default:  decode_mode = SEL_MEDIAN;
        endcase
    endfunction

endpackage

// File: rtl/filter_ring_ptr.sv
// Wrapping window index; relies on the window depth being a power of two.
module filter_ring_ptr #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              incr,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (incr) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/filter_feeder.sv
// Feeds a valid/ready byte stream into the median filter window and flags settled
// medians of a full window; also zero-fills the window on request.
module filter_feeder
    import filter_pkg::*;
#(
    parameter int DATA_W        = filter_pkg::DATA_W,
    parameter int DEPTH         = filter_pkg::DEPTH,
    parameter int ADDR_W        = filter_pkg::ADDR_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush_req,
    input  logic [1:0]        mode_cfg,
    output logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              wr_enable,
    output logic [1:0]        out_select,
    output logic              window_full,
    output logic              result_valid
);

    localparam logic [ADDR_W:0]   FULL_COUNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    filter_feeder_state_t state;
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    flush_idx;
    logic [ADDR_W:0]      fill_count;
    logic [ADDR_W:0]      fill_inc;
    logic [3:0]           settle_cnt;
    logic                 flush_last;

    assign in_ready   = (state == ACCEPT) && !flush_req && !rst;
    assign fill_inc   = (fill_count == FULL_COUNT) ? fill_count : fill_count + (ADDR_W + 1)'(1);
    assign flush_last = (state == FLUSH) && (flush_idx == LAST_IDX);

    filter_ring_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_last),
        .incr  (state == WRITE),
        .ptr   (wr_ptr)
    );

    filter_ring_ptr #(.ADDR_W(ADDR_W)) u_flush_idx (
        .clk   (clk),
        .rst   (rst),
        .clear ((state == ACCEPT) && flush_req),
        .incr  (state == FLUSH),
        .ptr   (flush_idx)
    );

    // The flush issues its first zero write on entry so that every FLUSH cycle
    // carries a write strobe, with reg_addr running one step ahead of flush_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCEPT;
            fill_count   <= '0;
            window_full  <= 1'b0;
            settle_cnt   <= '0;
            data_in      <= '0;
            reg_addr     <= '0;
            wr_enable    <= 1'b0;
            out_select   <= '0;
            result_valid <= 1'b0;
        end else begin
            wr_enable    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                ACCEPT: begin
                    out_select <= decode_mode(mode_cfg);
                    if (flush_req) begin
                        state     <= FLUSH;
                        wr_enable <= 1'b1;
                        data_in   <= '0;
                        reg_addr  <= '0;
                    end else if (in_valid) begin
                        state     <= WRITE;
                        wr_enable <= 1'b1;
                        data_in   <= in_data;
                        reg_addr  <= wr_ptr;
                    end
                end
                WRITE: begin
                    fill_count  <= fill_inc;
                    window_full <= (fill_inc == FULL_COUNT);
                    if (SETTLE_CYCLES == 0) begin
                        state        <= ACCEPT;
                        result_valid <= (fill_inc == FULL_COUNT);
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state        <= ACCEPT;
                        result_valid <= (fill_count == FULL_COUNT);
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    if (flush_idx == LAST_IDX) begin
                        state       <= ACCEPT;
                        fill_count  <= '0;
                        window_full <= 1'b0;
                    end else begin
                        wr_enable <= 1'b1;
                        reg_addr  <= flush_idx + ADDR_W'(1);
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule
